// File: rtl/subservient_sram_arbiter_pkg.sv
// Shared types and widths for the SRAM arbiter: FSM states, requester ids,
// and the command payload presented to the 1rw1r macro.
package subservient_sram_arb_pkg;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned MW   = DW / 8;
  localparam int unsigned ADRW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_RDATA = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic [MW-1:0] sel;
  } mem_cmd_t;

endpackage

// File: rtl/subservient_sram_arbiter_if.sv
// Single-cycle-ack memory bus used by both the CPU and the debug requester.
interface subservient_sram_arbiter_if;
  import subservient_sram_arb_pkg::*;

  logic [ADRW-1:0] adr;
  logic [DW-1:0]   dat;
  logic [MW-1:0]   sel;
  logic            we;
  logic            stb;
  logic [DW-1:0]   rdt;
  logic            ack;

  modport master (output adr, dat, sel, we, stb, input rdt, ack);
  modport slave  (input adr, dat, sel, we, stb, output rdt, ack);

endinterface

// File: rtl/subservient_sram_arbiter_rr_arb2.sv
// Two-way round-robin picker; on a tie the requester that did not win last time is chosen.
module rr_arb2
  import subservient_sram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_e    last_i,
  output req_id_e    gnt_c_o,
  output logic       valid_c_o
);

  always_comb begin
    valid_c_o = |req_i;
    gnt_c_o   = REQ_CPU;
    if (req_i == 2'b11) begin
      gnt_c_o = (last_i == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (req_i[1]) begin
      gnt_c_o = REQ_DBG;
    end
  end

endmodule

// File: rtl/subservient_sram_arbiter.sv
// Shares one 1rw1r SRAM macro between CPU and debug buses: writes on port 0,
// reads on port 1, one access at a time, round-robin between requesters.
module subservient_sram_arbiter
  import subservient_sram_arb_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_cpu_hold,
  subservient_sram_arbiter_if.slave        cpu,
  subservient_sram_arbiter_if.slave        dbg,
  output logic                             o_csb0,
  output logic [MW-1:0]                    o_wmask0,
  output logic [AW-1:0]                    o_addr0,
  output logic [DW-1:0]                    o_din0,
  output logic                             o_csb1,
  output logic [AW-1:0]                    o_addr1,
  input  logic [DW-1:0]                    i_dout1
);

  state_e        state_q, state_d;
  req_id_e       last_q, last_d;
  req_id_e       id_q, id_d;
  logic          we_q, we_d;
  logic          csb0_q, csb0_d, csb1_q, csb1_d;
  logic [MW-1:0] wmask0_q, wmask0_d;
  logic [AW-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DW-1:0] din0_q, din0_d;
  logic          cpu_ack_q, cpu_ack_d, dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] cpu_rdt_q, cpu_rdt_d, dbg_rdt_q, dbg_rdt_d;

  req_id_e       gnt_id_c;
  logic          gnt_valid_c;
  mem_cmd_t      cmd_c;
  logic          unused_adr_bits;

  // Upper and byte-lane address bits are ignored: the 256-word array aliases.
  assign unused_adr_bits = ^{cpu.adr[ADRW-1:AW+2], cpu.adr[1:0],
                             dbg.adr[ADRW-1:AW+2], dbg.adr[1:0]};

  rr_arb2 u_rr_arb2 (
    .req_i     ({dbg.stb, cpu.stb & ~i_cpu_hold}),
    .last_i    (last_q),
    .gnt_c_o   (gnt_id_c),
    .valid_c_o (gnt_valid_c)
  );

  always_comb begin
    if (gnt_id_c == REQ_CPU) begin
      cmd_c = '{we: cpu.we, addr: cpu.adr[AW+1:2], dat: cpu.dat, sel: cpu.sel};
    end else begin
      cmd_c = '{we: dbg.we, addr: dbg.adr[AW+1:2], dat: dbg.dat, sel: dbg.sel};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= REQ_DBG;
      id_q      <= REQ_CPU;
      we_q      <= 1'b0;
      csb0_q    <= 1'b1;
      csb1_q    <= 1'b1;
      wmask0_q  <= '0;
      addr0_q   <= '0;
      addr1_q   <= '0;
      din0_q    <= '0;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      cpu_rdt_q <= '0;
      dbg_rdt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      we_q      <= we_d;
      csb0_q    <= csb0_d;
      csb1_q    <= csb1_d;
      wmask0_q  <= wmask0_d;
      addr0_q   <= addr0_d;
      addr1_q   <= addr1_d;
      din0_q    <= din0_d;
      cpu_ack_q <= cpu_ack_d;
      dbg_ack_q <= dbg_ack_d;
      cpu_rdt_q <= cpu_rdt_d;
      dbg_rdt_q <= dbg_rdt_d;
    end
  end

  // Chip selects are only ever low for the single CMD cycle.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    we_d      = we_q;
    csb0_d    = 1'b1;
    csb1_d    = 1'b1;
    wmask0_d  = wmask0_q;
    addr0_d   = addr0_q;
    addr1_d   = addr1_q;
    din0_d    = din0_q;
    cpu_ack_d = 1'b0;
    dbg_ack_d = 1'b0;
    cpu_rdt_d = cpu_rdt_q;
    dbg_rdt_d = dbg_rdt_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          state_d = ST_CMD;
          last_d  = gnt_id_c;
          id_d    = gnt_id_c;
          we_d    = cmd_c.we;
          if (cmd_c.we) begin
            csb0_d   = ~(|cmd_c.sel);
            wmask0_d = cmd_c.sel;
            addr0_d  = cmd_c.addr;
            din0_d   = cmd_c.dat;
          end else begin
            csb1_d  = 1'b0;
            addr1_d = cmd_c.addr;
          end
        end
      end
      ST_CMD: begin
        if (we_q) begin
          state_d   = ST_ACK;
          cpu_ack_d = (id_q == REQ_CPU);
          dbg_ack_d = (id_q == REQ_DBG);
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        state_d = ST_ACK;
        if (id_q == REQ_CPU) begin
          cpu_rdt_d = i_dout1;
          cpu_ack_d = 1'b1;
        end else begin
          dbg_rdt_d = i_dout1;
          dbg_ack_d = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_csb0   = csb0_q;
  assign o_wmask0 = wmask0_q;
  assign o_addr0  = addr0_q;
  assign o_din0   = din0_q;
  assign o_csb1   = csb1_q;
  assign o_addr1  = addr1_q;
  assign cpu.ack  = cpu_ack_q;
  assign cpu.rdt  = cpu_rdt_q;
  assign dbg.ack  = dbg_ack_q;
  assign dbg.rdt  = dbg_rdt_q;

endmodule
